// File: rtl/segre_pkg.sv
// Shared defaults, entry layout and controller states for the set-associative icache tag store.
package segre_pkg;

    localparam int ICACHE_NUM_SETS = 16;
    localparam int ICACHE_NUM_WAYS = 4;
    localparam int ICACHE_TAG_SIZE = 22;

    // Stored tag is sized for the widest supported tag; narrower instances use the low bits.
    typedef struct packed {
        logic                       valid;
        logic [ICACHE_TAG_SIZE-1:0] tag;
    } tag_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } tag_state_e;

endpackage

// File: rtl/segre_icache_tag_sa_if.sv
// Fetch/refill-side bundle of the icache tag store: lookup, fill and flush channels.
interface segre_icache_tag_sa_if #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    parameter int TAG_SIZE = 22
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic                req_i;
    logic [SET_W-1:0]    index_i;
    logic [TAG_SIZE-1:0] tag_i;
    logic                ready_o;
    logic                hit_o;
    logic                miss_o;
    logic [WAY_W-1:0]    way_o;
    logic [WAY_W-1:0]    victim_way_o;
    logic                fill_valid_i;
    logic [SET_W-1:0]    fill_index_i;
    logic [WAY_W-1:0]    fill_way_i;
    logic [TAG_SIZE-1:0] fill_tag_i;
    logic                invalidate_i;
    logic                flush_done_o;

    modport master (
        output req_i, index_i, tag_i, fill_valid_i, fill_index_i, fill_way_i, fill_tag_i,
               invalidate_i,
        input  ready_o, hit_o, miss_o, way_o, victim_way_o, flush_done_o
    );

    modport slave (
        input  req_i, index_i, tag_i, fill_valid_i, fill_index_i, fill_way_i, fill_tag_i,
               invalidate_i,
        output ready_o, hit_o, miss_o, way_o, victim_way_o, flush_done_o
    );

endinterface

// File: rtl/segre_plru_tree.sv
// Heap-ordered tree pseudo-LRU: victim from tree bits, and tree bits after touching a way.
module segre_plru_tree #(
    parameter int NUM_WAYS = 4,
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] tree_i,
    input  logic [WAY_W-1:0]    way_i,
    output logic [WAY_W-1:0]    victim_o,
    output logic [NUM_WAYS-2:0] tree_o
);

    // Bit 0 at a node steers the victim to the lower-indexed child (2n+1).
    always_comb begin
        int unsigned node;
        node     = 0;
        victim_o = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim_o[WAY_W-1-l] = tree_i[node];
            node = 2 * node + 1 + 32'(tree_i[node]);
        end
    end

    always_comb begin
        int unsigned node;
        logic        dir;
        node   = 0;
        tree_o = tree_i;
        for (int l = 0; l < WAY_W; l++) begin
            dir          = way_i[WAY_W-1-l];
            tree_o[node] = ~dir;
            node = 2 * node + 1 + 32'(dir);
        end
    end

endmodule

// File: rtl/segre_icache_tag_sa.sv
// Set-associative icache tag store with pLRU replacement, one-cycle registered lookup,
// way-addressed fill and a one-set-per-cycle flush sequencer.
//
// state | meaning
// IDLE  | ready; accepts lookups, fills and invalidate
// FLUSH | clears valid and pLRU bits of one set per cycle, set 0 first
module segre_icache_tag_sa
    import segre_pkg::*;
#(
    parameter int NUM_SETS = ICACHE_NUM_SETS,
    parameter int NUM_WAYS = ICACHE_NUM_WAYS,
    parameter int TAG_SIZE = ICACHE_TAG_SIZE
) (
    input logic                  clk_i,
    input logic                  rst_i,
    segre_icache_tag_sa_if.slave bus
);

    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int TREE_W = NUM_WAYS - 1;
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

    tag_entry_t        entries_q [NUM_SETS][NUM_WAYS];
    logic [TREE_W-1:0] tree_q [NUM_SETS];

    tag_state_e       state_q, state_d;
    logic [SET_W-1:0] flush_set_q, flush_set_d;
    logic             flush_last;

    logic             hit_q, miss_q;
    logic [WAY_W-1:0] way_q, victim_q;

    logic                lookup_go, fill_go;
    logic [NUM_WAYS-1:0] hit_vec, inv_vec;
    logic                hit_any, inv_any;
    logic [WAY_W-1:0]    hit_way, inv_way, tree_victim, victim_way;
    logic [TREE_W-1:0]   hit_tree, lookup_tree, fill_base, fill_tree;

    logic [WAY_W-1:0]  lookup_victim_unused, fill_victim_unused;
    logic [TREE_W-1:0] victim_tree_unused;
    logic              unused_plru;

    assign unused_plru = ^{lookup_victim_unused, fill_victim_unused, victim_tree_unused};

    // A simultaneous invalidate drops the lookup and fill.
    assign lookup_go = (state_q == IDLE) && bus.req_i && !bus.invalidate_i;
    assign fill_go   = (state_q == IDLE) && bus.fill_valid_i && !bus.invalidate_i;

    always_comb begin
        state_d     = state_q;
        flush_set_d = flush_set_q;
        flush_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.invalidate_i) begin
                    state_d     = FLUSH;
                    flush_set_d = '0;
                end
            end
            FLUSH: begin
                flush_set_d = flush_set_q + SET_W'(1);
                if (flush_set_q == LAST_SET) begin
                    flush_last  = 1'b1;
                    state_d     = IDLE;
                    flush_set_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit_vec = '0;
        inv_vec = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = entries_q[bus.index_i][w].valid &&
                         (entries_q[bus.index_i][w].tag[TAG_SIZE-1:0] == bus.tag_i);
            inv_vec[w] = !entries_q[bus.index_i][w].valid;
        end
    end

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (inv_vec[w]) inv_way = WAY_W'(w);
        end
    end

    assign hit_any    = |hit_vec;
    assign inv_any    = |inv_vec;
    assign victim_way = inv_any ? inv_way : tree_victim;

    // Fill to the lookup's set builds on the post-hit tree so its path bits win.
    assign lookup_tree = (lookup_go && hit_any) ? hit_tree : tree_q[bus.index_i];
    assign fill_base   = (bus.fill_index_i == bus.index_i) ? lookup_tree
                                                          : tree_q[bus.fill_index_i];

    segre_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_lookup (
        .tree_i   (tree_q[bus.index_i]),
        .way_i    (hit_way),
        .victim_o (lookup_victim_unused),
        .tree_o   (hit_tree)
    );

    segre_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_fill (
        .tree_i   (fill_base),
        .way_i    (bus.fill_way_i),
        .victim_o (fill_victim_unused),
        .tree_o   (fill_tree)
    );

    segre_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_victim (
        .tree_i   (tree_q[bus.index_i]),
        .way_i    ('0),
        .victim_o (tree_victim),
        .tree_o   (victim_tree_unused)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            flush_set_q <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            way_q       <= '0;
            victim_q    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                tree_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    entries_q[s][w] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            flush_set_q <= flush_set_d;
            hit_q       <= lookup_go && hit_any;
            miss_q      <= lookup_go && !hit_any;
            if (lookup_go) begin
                way_q    <= hit_way;
                victim_q <= victim_way;
            end
            if (lookup_go && hit_any) begin
                tree_q[bus.index_i] <= hit_tree;
            end
            if (fill_go) begin
                entries_q[bus.fill_index_i][bus.fill_way_i].valid <= 1'b1;
                entries_q[bus.fill_index_i][bus.fill_way_i].tag   <=
                    ICACHE_TAG_SIZE'(bus.fill_tag_i);
                tree_q[bus.fill_index_i] <= fill_tree;
            end
            if (state_q == FLUSH) begin
                tree_q[flush_set_q] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    entries_q[flush_set_q][w].valid <= 1'b0;
                end
            end
        end
    end

    assign bus.ready_o      = (state_q == IDLE);
    assign bus.hit_o        = hit_q;
    assign bus.miss_o       = miss_q;
    assign bus.way_o        = way_q;
    assign bus.victim_way_o = victim_q;
    assign bus.flush_done_o = flush_last;

endmodule

// File: tb/tb_segre_icache_tag_sa.sv
// Scoreboard bench for segre_icache_tag_sa: directed lookups/fills/flushes with queued expectations.
module tb_segre_icache_tag_sa;

    typedef struct {
        logic       hit;
        logic [1:0] way;
        logic [1:0] victim;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int n_lookups = 0;
    int done_pulses = 0;

    exp_t exp_q[$];
    exp_t cur;

    segre_icache_tag_sa_if #(.NUM_SETS(16), .NUM_WAYS(4), .TAG_SIZE(22)) bus ();

    segre_icache_tag_sa #(.NUM_SETS(16), .NUM_WAYS(4), .TAG_SIZE(22)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every presented response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.flush_done_o) done_pulses++;
        if (bus.hit_o || bus.miss_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp got hit=%0d miss=%0d way=%0d victim=%0d want none",
                         bus.hit_o, bus.miss_o, bus.way_o, bus.victim_way_o);
            end else begin
                cur = exp_q.pop_front();
                if (bus.hit_o !== cur.hit || bus.miss_o !== !cur.hit ||
                    (cur.hit && bus.way_o !== cur.way) ||
                    (!cur.hit && bus.victim_way_o !== cur.victim)) begin
                    errors++;
                    $display("FAIL lookup_%0d got hit=%0d miss=%0d way=%0d victim=%0d want hit=%0d way=%0d victim=%0d",
                             cur.id, bus.hit_o, bus.miss_o, bus.way_o, bus.victim_way_o,
                             cur.hit, cur.way, cur.victim);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic lookup(input int s, input int t, input logic eh, input int ew, input int ev);
        exp_t e;
        e.hit    = eh;
        e.way    = 2'(ew);
        e.victim = 2'(ev);
        e.id     = n_lookups;
        n_lookups++;
        exp_q.push_back(e);
        bus.req_i   = 1'b1;
        bus.index_i = 4'(s);
        bus.tag_i   = 22'(t);
        cycle();
        bus.req_i = 1'b0;
    endtask

    task automatic set_fill(input int s, input int w, input int t);
        bus.fill_valid_i = 1'b1;
        bus.fill_index_i = 4'(s);
        bus.fill_way_i   = 2'(w);
        bus.fill_tag_i   = 22'(t);
    endtask

    task automatic fill(input int s, input int w, input int t);
        set_fill(s, w, t);
        cycle();
        bus.fill_valid_i = 1'b0;
    endtask

    initial begin
        int low_cnt;
        int pulses_before;

        bus.req_i = 1'b0;        bus.index_i = '0;      bus.tag_i = '0;
        bus.fill_valid_i = 1'b0; bus.fill_index_i = '0; bus.fill_way_i = '0;
        bus.fill_tag_i = '0;     bus.invalidate_i = 1'b0;

        cycle();
        cycle();
        rst = 1'b0;

        check("rst_ready", 32'(bus.ready_o), 1);
        check("rst_hit", 32'(bus.hit_o), 0);
        check("rst_miss", 32'(bus.miss_o), 0);
        check("rst_way", 32'(bus.way_o), 0);
        check("rst_victim", 32'(bus.victim_way_o), 0);
        check("rst_flush_done", 32'(bus.flush_done_o), 0);

        // Cold miss
        lookup(3, 'h1234, 1'b0, 0, 0);
        cycle();
        check("ready_after_lookup", 32'(bus.ready_o), 1);

        // Fill set 3, hit way 2, then tree-driven victims
        for (int w = 0; w < 4; w++) fill(3, w, 'hA + w);
        lookup(3, 'hC, 1'b1, 2, 0);
        lookup(3, 'h55, 1'b0, 0, 0);
        lookup(3, 'hA, 1'b1, 0, 0);
        lookup(3, 'h99, 1'b0, 0, 3);

        // Partially valid set: lowest invalid way wins
        fill(9, 0, 'h900);
        fill(9, 2, 'h902);
        lookup(9, 'h999, 1'b0, 0, 1);

        // Back-to-back hits in set 5
        for (int w = 0; w < 4; w++) fill(5, w, 'h100 + w);
        for (int w = 0; w < 4; w++) lookup(5, 'h100 + w, 1'b1, w, 0);
        lookup(5, 'h555, 1'b0, 0, 0);
        lookup(5, 'h100, 1'b1, 0, 0);
        lookup(5, 'h555, 1'b0, 0, 2);

        // Same-cycle hit (way 3) and fill (way 1): fill path bits must win
        set_fill(5, 1, 'h101);
        lookup(5, 'h103, 1'b1, 3, 0);
        bus.fill_valid_i = 1'b0;
        lookup(5, 'h555, 1'b0, 0, 2);

        // Same-cycle fill and lookup in set 7: lookup sees pre-fill contents
        set_fill(7, 1, 'h777);
        lookup(7, 'h777, 1'b0, 0, 0);
        bus.fill_valid_i = 1'b0;
        lookup(7, 'h777, 1'b1, 1, 0);
        cycle();

        // Flush; invalidate wins over simultaneous lookup and fill
        pulses_before = done_pulses;
        bus.invalidate_i = 1'b1;
        bus.req_i = 1'b1; bus.index_i = 4'd3; bus.tag_i = 22'hC;
        set_fill(3, 0, 'hEE);
        cycle();
        bus.invalidate_i = 1'b0; bus.req_i = 1'b0; bus.fill_valid_i = 1'b0;
        check("flush_ready_fall", 32'(bus.ready_o), 0);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.ready_o) low_cnt++;
            if (i == 3) begin
                bus.req_i = 1'b1; bus.index_i = 4'd5; bus.tag_i = 22'h100;
            end
            if (i == 6) begin
                bus.invalidate_i = 1'b1;
                set_fill(9, 1, 'h901);
            end
            cycle();
            bus.req_i = 1'b0; bus.invalidate_i = 1'b0; bus.fill_valid_i = 1'b0;
        end
        check("flush_low_cycles", 32'(low_cnt), 16);
        check("flush_done_pulses", 32'(done_pulses - pulses_before), 1);
        lookup(3, 'hC, 1'b0, 0, 0);
        lookup(5, 'h100, 1'b0, 0, 0);
        lookup(9, 'h901, 1'b0, 0, 0);

        // Reset in the middle of a flush
        fill(2, 0, 'h42);
        fill(12, 1, 'h43);
        lookup(2, 'h42, 1'b1, 0, 0);
        cycle();
        pulses_before = done_pulses;
        bus.invalidate_i = 1'b1;
        cycle();
        bus.invalidate_i = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midflush_rst_ready", 32'(bus.ready_o), 1);
        for (int i = 0; i < 20; i++) cycle();
        check("midflush_no_done", 32'(done_pulses - pulses_before), 0);
        lookup(2, 'h42, 1'b0, 0, 0);
        lookup(12, 'h43, 1'b0, 0, 0);
        lookup(12, 'h0, 1'b0, 0, 0);

        cycle();
        cycle();
        check("pending_expectations", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
